dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words stored; it is a power of two and at least 16.
REQ-002 SHALL have parameter LATENCY, default 2, the number of cycles from request acceptance to dmem_resp; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit, the clock.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port dmem_addr, input, 32 bits, the byte address; bits [1:0] are ignored.
REQ-006 SHALL have port dmem_rmask, input, 4 bits, the byte read enables.
REQ-007 SHALL have port dmem_wmask, input, 4 bits, the byte write enables.
REQ-008 SHALL have port dmem_wdata, input, 32 bits, the write data, lane-aligned.
REQ-009 SHALL have port dmem_rdata, output, 32 bits, the full word read.
REQ-010 SHALL have port dmem_resp, output, 1 bit, a one-cycle completion pulse.
REQ-011 SHALL have port dmem_err, output, 1 bit, pulsed with dmem_resp when the completed request was illegal.

Function
REQ-012 SHALL treat a request as present when dmem_rmask or dmem_wmask is nonzero.
REQ-013 SHALL use an FSM with states IDLE, WAIT and RESP.
REQ-014 SHALL, in IDLE with a request present, latch the address, masks and write data, load the latency counter, and go to WAIT, or straight to RESP when LATENCY=1.
REQ-015 SHALL ignore the inputs in WAIT and RESP; the requester holds them stable and they are not re-sampled.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and enter RESP when the counter reaches 1.
REQ-017 SHALL, for a request accepted at edge N, assert dmem_resp for exactly one cycle, the one following edge N+LATENCY.
REQ-018 SHALL return from RESP to IDLE unconditionally.
REQ-019 SHALL NOT accept a request in the RESP cycle itself.
REQ-020 SHALL make the requester drop both masks for at least one cycle after dmem_resp; a request still held in IDLE SHALL be accepted again as a new request.
REQ-021 SHALL select the word by index = latched addr[2 +: log2(DEPTH_WORDS)]; higher address bits alias, so wrap-around is silent.
REQ-022 SHALL, on a read, drive dmem_rdata with the full stored word during the resp cycle, regardless of rmask lanes.
REQ-023 SHALL hold dmem_rdata at its last value in all other cycles.
REQ-024 SHALL, on a write, commit only the byte lanes enabled in wmask, on the edge that enters RESP.
REQ-025 SHALL drive dmem_rdata to 0 in the resp cycle of a write.
REQ-026 SHALL make a committed write visible to any later-accepted read.
REQ-027 SHALL treat a request with both masks nonzero as illegal: perform the write, drive dmem_rdata to 0, and assert dmem_err with dmem_resp.
REQ-028 SHALL keep at most one request outstanding; there is no queue.

Reset
REQ-029 SHALL, on rst, set state=IDLE, counter=0, dmem_resp=0, dmem_err=0, dmem_rdata=0.
REQ-030 SHALL, on rst mid-operation, abandon the request: no resp is produced and an uncommitted write is dropped.
REQ-031 SHALL leave memory contents unchanged by rst; contents are undefined only at power-up.

Configuration
REQ-032 SHALL, when DMEM_RESP_RANDOM_STALL_EN is defined, add 0..3 extra WAIT cycles per request, taken from lfsr[1:0] sampled at acceptance.
REQ-033 SHALL, under that macro, use a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1) seeded to 16'hACE1 on rst and advanced every cycle.
REQ-034 SHALL, without the macro, have latency exactly LATENCY and contain no LFSR logic.

Structure
REQ-035 SHALL place the dmem_resp_state_t enum (IDLE/WAIT/RESP) in package rv32i_types.
REQ-036 SHALL keep LATENCY and DEPTH_WORDS as module parameters, not package constants.
REQ-037 SHALL implement the LFSR as sub-module dmem_lfsr, instantiated only under DMEM_RESP_RANDOM_STALL_EN.
REQ-038 SHALL infer the storage as a byte-enabled register array.

Verification
REQ-039 Bench SHALL cover: write addr 0x100, wmask 4'b1111, wdata 0xDEADBEEF, then read 0x100 rmask 4'b1111 -> rdata 0xDEADBEEF, each resp exactly LATENCY cycles after acceptance.
REQ-040 Bench SHALL cover: write 0x104 with 0x11223344, then wmask 4'b0100, wdata 0x00AA0000 -> read 0x104 returns 0x11AA3344.
REQ-041 Bench SHALL cover: with DEPTH_WORDS=1024, write 0x0000_1008 with 0xCAFEF00D -> read 0x0000_0008 returns 0xCAFEF00D (aliasing).
REQ-042 Bench SHALL cover: rmask=4'b0001 and wmask=4'b0001 together -> resp plus dmem_err=1, rdata=0, and the byte is written.
REQ-043 Bench SHALL cover: rst asserted the cycle after accepting a write of 0x55 to 0x200 -> no resp, and a later read of 0x200 returns the old value.
REQ-044 Bench SHALL cover: request held through resp without dropping the masks -> a second resp arrives LATENCY+1 cycles after the first; with DMEM_RESP_RANDOM_STALL_EN, latency is always in LATENCY..LATENCY+3.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder: FSM state encoding and latched request payload.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_resp_state_t;

   typedef struct packed {
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_lfsr.sv
// 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1) supplying random stall counts.
// Only compiled when DMEM_RESP_RANDOM_STALL_EN is defined.
`ifdef DMEM_RESP_RANDOM_STALL_EN
module dmem_lfsr (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] stall_o
);

   logic [15:0] lfsr_q, lfsr_d;
   logic        fb_c;

   // Right-shifting form of the polynomial; taps at bits 0,2,3,5
   always_comb begin
      fb_c   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      lfsr_d = {fb_c, lfsr_q[15:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end

   assign stall_o = lfsr_q[1:0];

endmodule
`endif

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed latency and byte-lane writes.
// Define DMEM_RESP_RANDOM_STALL_EN to add 0..3 random extra wait cycles per request.
module dmem_responder
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic        dmem_err
);

   localparam int unsigned AW    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 5;

   dmem_resp_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, load_c;
   dmem_req_t        req_q, req_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             resp_q, resp_d;
   logic             err_q, err_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             mem_we_c;
   logic [1:0]       stall_c;
   logic             unused_addr_c;

   logic [3:0][7:0]  mem_q [DEPTH_WORDS];

`ifdef DMEM_RESP_RANDOM_STALL_EN
   dmem_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .stall_o (stall_c)
   );
`else
   assign stall_c = 2'b00;
`endif

   // Upper address bits alias and the byte offset is ignored
   assign unused_addr_c = ^{dmem_addr[31:2+AW], dmem_addr[1:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      req_d    = req_q;
      idx_d    = idx_q;
      resp_d   = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      mem_we_c = 1'b0;
      load_c   = CNT_W'(LATENCY) + CNT_W'(stall_c);

      case (state_q)
         IDLE: begin
            if ((|dmem_rmask) || (|dmem_wmask)) begin
               req_d = '{rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
               idx_d = dmem_addr[2 +: AW];
               cnt_d = load_c;
               if (load_c == CNT_W'(1)) begin
                  state_d  = RESP;
                  mem_we_c = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(2)) begin
               state_d  = RESP;
               mem_we_c = 1'b1;
            end
         end
         RESP: begin
            // dmem_resp is registered, so the pulse lands in the cycle after RESP
            state_d = IDLE;
            cnt_d   = '0;
            resp_d  = 1'b1;
            err_d   = (|req_q.rmask) && (|req_q.wmask);
            rdata_d = (|req_q.wmask) ? 32'd0 : mem_q[idx_q];
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         idx_q   <= '0;
         resp_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         idx_q   <= idx_d;
         resp_q  <= resp_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage is not reset; a write abandoned by rst never commits
   always_ff @(posedge clk) begin
      if (!rst && mem_we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (req_d.wmask[b]) mem_q[idx_d][b] <= req_d.wdata[8*b +: 8];
         end
      end
   end

   assign dmem_rdata = rdata_q;
   assign dmem_resp  = resp_q;
   assign dmem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expectations, a monitor pops on dmem_resp.
module tb_dmem_responder;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic        dmem_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   last_resp = 0;
   int   lat;
   int   n_checks = 0;
   int   n_pass = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .dmem_addr  (dmem_addr),
      .dmem_rmask (dmem_rmask),
      .dmem_wmask (dmem_wmask),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_resp  (dmem_resp),
      .dmem_err   (dmem_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every response pops one expectation; acc < 0 means "accepted right after the previous resp"
   always @(negedge clk) begin
      if (dmem_resp) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("rdata", dmem_rdata, e.rdata);
            check("err", {31'd0, dmem_err}, {31'd0, e.err});
            lat = cyc - ((e.acc < 0) ? last_resp + 1 : e.acc);
`ifdef DMEM_RESP_RANDOM_STALL_EN
            check("latency_range", {31'd0, (lat >= LAT) && (lat <= LAT + 3)}, 32'd1);
`else
            check("latency", 32'(lat), 32'(LAT));
`endif
         end
         last_resp = cyc;
      end
   end

   task automatic wait_resp();
      bit got = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dmem_resp) begin
            got = 1;
            break;
         end
      end
      if (!got) check("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
      @(negedge clk);
      dmem_addr  = a;
      dmem_rmask = rm;
      dmem_wmask = wm;
      dmem_wdata = wd;
      sb.push_back('{rdata: exp_rd, err: exp_err, acc: cyc + 1});
      wait_resp();
      dmem_rmask = 4'h0;
      dmem_wmask = 4'h0;
   endtask

   initial begin
      rst        = 1'b1;
      dmem_addr  = '0;
      dmem_rmask = '0;
      dmem_wmask = '0;
      dmem_wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_rdata", dmem_rdata, 32'd0);
      check("reset_resp", {31'd0, dmem_resp}, 32'd0);
      check("reset_err", {31'd0, dmem_err}, 32'd0);
      rst = 1'b0;

      // Basic write then read
      req(32'h100, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
      req(32'h100, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
      // Partial lane merge; a narrow rmask still returns the full word
      req(32'h104, 4'h0, 4'hF, 32'h11223344, 32'h0, 1'b0);
      req(32'h104, 4'h0, 4'b0100, 32'h00AA0000, 32'h0, 1'b0);
      req(32'h104, 4'b0001, 4'h0, 32'h0, 32'h11AA3344, 1'b0);
      req(32'h110, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0);
      req(32'h110, 4'h0, 4'b1010, 32'h12003400, 32'h0, 1'b0);
      req(32'h110, 4'hF, 4'h0, 32'h0, 32'h12FF34FF, 1'b0);
      // Address aliasing at 1024 words
      req(32'h0000_1008, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
      req(32'h0000_0008, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);
      // Illegal read+write: error, rdata 0, byte still written
      req(32'h10C, 4'h0, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0);
      req(32'h10C, 4'b0001, 4'b0001, 32'h0000003C, 32'h0, 1'b1);
      req(32'h10C, 4'hF, 4'h0, 32'h0, 32'hA5A5A53C, 1'b0);

      // Reset right after accepting a write drops it and suppresses the resp
      req(32'h200, 4'h0, 4'hF, 32'h12345678, 32'h0, 1'b0);
      req(32'h200, 4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0);
      @(negedge clk);
      dmem_addr  = 32'h200;
      dmem_wmask = 4'b0001;
      dmem_wdata = 32'h00000055;
      @(negedge clk);
      rst        = 1'b1;
      dmem_wmask = 4'h0;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_rdata", dmem_rdata, 32'd0);
      check("midrst_resp", {31'd0, dmem_resp}, 32'd0);
      check("midrst_err", {31'd0, dmem_err}, 32'd0);
      repeat (8) @(negedge clk);
      req(32'h200, 4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0);

      // Held request is re-accepted after the first resp
      @(negedge clk);
      dmem_addr  = 32'h100;
      dmem_rmask = 4'hF;
      sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, acc: cyc + 1});
      sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, acc: -1});
      wait_resp();
      wait_resp();
      dmem_rmask = 4'h0;

      repeat (10) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
